// File: rtl/flopenr.sv
// Memory-subsystem storage primitives: enabled register, plain register
// and a 2-to-4 one-hot decoder.

module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic             w_unused_ph2;

  // ph2 exists only to keep the codebase's pin order
  assign w_unused_ph2 = ph2;

  always_ff @(posedge ph1) begin
    if (reset)
      r_q <= '0;
    else if (en)
      r_q <= d;
  end

  assign q = r_q;

endmodule

module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  flopenr #(
    .WIDTH (WIDTH)
  ) u_reg (
    .ph1   (ph1),
    .ph2   (ph2),
    .reset (reset),
    .en    (1'b1),
    .d     (d),
    .q     (q)
  );

endmodule

module dec2 (
  input  logic [1:0] x,
  output logic [3:0] y
);

  // an unknown shift amount yields all-X, so X/Z on x propagates
  assign y = 4'b0001 << x;

endmodule

// File: tb/tb_flopenr.sv
// Directed self-checking bench for flopenr, flopr and dec2.

module tb_flopenr;

  logic ph1 = 1'b0;
  logic ph2 = 1'b0;

  always #5 ph1 = ~ph1;

  int checks = 0;
  int errors = 0;

  logic        rst32, en32;
  logic [31:0] d32, q32;
  logic        rst27, en27;
  logic [26:0] d27, q27;
  logic        rstp, enp;
  logic [1:0]  dp, qp;
  logic        rstc, enc;
  logic [1:0]  dc, qc;
  logic        rstf;
  logic [1:0]  df, qf;
  logic [1:0]  x;
  logic [3:0]  y;
  logic [3:0]  dec_exp [4];

  flopenr #(.WIDTH(32)) u_r32 (
    .ph1(ph1), .ph2(ph2), .reset(rst32),
    .en(en32), .d(d32), .q(q32)
  );

  flopenr #(.WIDTH(27)) u_r27 (
    .ph1(ph1), .ph2(ph2), .reset(rst27),
    .en(en27), .d(d27), .q(q27)
  );

  flopenr #(.WIDTH(2)) u_rp (
    .ph1(ph1), .ph2(ph2), .reset(rstp),
    .en(enp), .d(dp), .q(qp)
  );

  flopenr #(.WIDTH(2)) u_cnt (
    .ph1(ph1), .ph2(ph2), .reset(rstc),
    .en(enc), .d(dc), .q(qc)
  );

  assign dc = qc + 2'd1;

  flopr #(.WIDTH(2)) u_fr (
    .ph1(ph1), .ph2(ph2), .reset(rstf),
    .d(df), .q(qf)
  );

  dec2 u_dec (
    .x(x), .y(y)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  initial begin
    dec_exp[0] = 4'b0001;
    dec_exp[1] = 4'b0010;
    dec_exp[2] = 4'b0100;
    dec_exp[3] = 4'b1000;

    rst32 = 1; en32 = 1; d32 = 32'hDEADBEEF;
    rst27 = 1; en27 = 0; d27 = '0;
    rstp  = 1; enp  = 0; dp  = '0;
    rstc  = 1; enc  = 0;
    rstf  = 1; df   = '0;
    x     = '0;

    // reset with en=1 and live data still clears
    tick();
    check("r32_rst", q32, 32'h0);
    check("r27_rst", q27, 32'h0);
    check("cnt_rst", qc, 32'h0);
    check("fr_rst", qf, 32'h0);

    rst32 = 0; rst27 = 0; rstp = 0;
    rstc  = 0; rstf  = 0;
    tick();
    check("r32_load", q32, 32'hDEADBEEF);

    // enable hold
    en27 = 1; d27 = 27'h4AD;
    tick();
    check("r27_load", q27, 32'h4AD);
    en27 = 0; d27 = 27'h0AD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("r27_hold%0d", i), q27, 32'h4AD);
    end
    en27 = 1;
    tick();
    check("r27_reload", q27, 32'h0AD);

    // reset priority over enable
    enp = 1; dp = 2'b11;
    tick();
    check("rp_load", qp, 32'h3);
    rstp = 1; dp = 2'b10;
    tick();
    check("rp_prio", qp, 32'h0);
    rstp = 0;
    tick();
    check("rp_resume", qp, 32'h2);

    // 2-bit counter wrap then freeze
    enc = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("cnt%0d", i), qc, 32'(i % 4));
    end
    tick();
    enc = 0;
    check("cnt_pre_frz", qc, 32'h1);
    tick();
    check("cnt_frz0", qc, 32'h1);
    tick();
    check("cnt_frz1", qc, 32'h1);

    // flopr follows d one edge later
    df = 2'b01;
    tick();
    check("fr_01", qf, 32'h1);
    df = 2'b10;
    tick();
    check("fr_10", qf, 32'h2);
    df = 2'b11;
    tick();
    check("fr_11", qf, 32'h3);

    // ph2 and d wiggle between ph1 edges
    en32 = 1; d32 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ph2 = ~ph2;
      df  = 2'(i);
      d32 = 32'(i);
      #1;
    end
    check("fr_ph2", qf, 32'h3);
    check("r32_ph2", q32, 32'hDEADBEEF);
    check("r27_ph2", q27, 32'h0AD);
    tick();
    check("fr_after", qf, 32'h3);
    check("r32_after", q32, 32'h3);

    // decoder sweep
    for (int i = 0; i < 4; i++) begin
      x = 2'(i);
      #1;
      check($sformatf("dec%0d", i), y, dec_exp[i]);
      check($sformatf("dec%0d_1hot", i), $countones(y), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
